fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and the fetch FSM state type for the pipeline front end.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Handshake: imem_req is held high while fetching; imem_rdata belongs to imem_addr and is
// consumed only in a cycle where imem_req and imem_ready are both high.
interface fetch_stage_if;

   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, bubble replaces only the
// instruction/valid fields so the PC fields keep their last values; neither means hold.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   output logic [31:0] pc_D,
   output logic [31:0] pc_plus4_D,
   output logic [31:0] instr_D,
   output logic        valid_D
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_D       <= 32'h0;
         pc_plus4_D <= 32'h0;
         instr_D    <= NOP;
         valid_D    <= 1'b0;
      end else if (load) begin
         pc_D       <= pc;
         pc_plus4_D <= pc_plus4;
         instr_D    <= instr;
         valid_D    <= 1'b1;
      end else if (bubble) begin
         instr_D    <= NOP;
         valid_D    <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and the IF/ID register.
// Optional stall-cycle counter output is built when FETCH_STALL_CNT_EN is defined.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic [31:0]   branch_target,
   fetch_stage_if.master imem,
   output logic [31:0]   pc_D,
   output logic [31:0]   pc_plus4_D,
   output logic [31:0]   instr_D,
   output logic          valid_D,
   output logic          fetch_fault,
   output fetch_state_e  fsm_state
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   fetch_state_e state, state_n;
   logic [31:0]  pc_f, pc_f_n;
   logic [31:0]  pc_f_plus4;
   logic         fault_n;
   logic         load, bubble;

   assign pc_f_plus4     = pc_f + 32'd4;
   assign imem.imem_addr = pc_f;
   assign fsm_state      = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc_f        <= RESET_PC;
         fetch_fault <= 1'b0;
      end else begin
         state       <= state_n;
         pc_f        <= pc_f_n;
         fetch_fault <= fault_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_f_n        = pc_f;
      fault_n       = fetch_fault;
      load          = 1'b0;
      bubble        = 1'b0;
      imem.imem_req = 1'b0;
      unique case (state)
         BOOT: state_n = RUN;
         RUN: begin
            imem.imem_req = 1'b1;
            if (flush) begin
               bubble = 1'b1;
               // A misaligned redirect is unrecoverable: stop fetching until reset.
               if (branch_target[1:0] == 2'b00) begin
                  pc_f_n = branch_target;
               end else begin
                  state_n = HALT;
                  fault_n = 1'b1;
               end
            end else if (stall) begin
               pc_f_n = pc_f;
            end else if (!imem.imem_ready) begin
               bubble = 1'b1;
            end else begin
               pc_f_n = pc_f_plus4;
               load   = 1'b1;
            end
         end
         HALT: state_n = HALT;
         default: state_n = BOOT;
      endcase
   end

   if_id_reg #(
      .NOP (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .bubble     (bubble),
      .pc         (pc_f),
      .pc_plus4   (pc_f_plus4),
      .instr      (imem.imem_rdata),
      .pc_D       (pc_D),
      .pc_plus4_D (pc_plus4_D),
      .instr_D    (instr_D),
      .valid_D    (valid_D)
   );

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'h0;
      end else if (state == RUN && stall && !flush && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
